frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
- Parametrised successor to the single-frame BRAM buffer that sits between the front CDC FIFO (camera side) and the back CDC FIFO (display side) in the system clock domain.
- Generalised in frame geometry and data width.
- Adds explicit frame-sync realignment, a frame-boundary-aligned freeze mode, and status/error outputs.
- Stores one frame in inferred BRAM and streams it out on each display request.

Parameters:
ROWLENGTH, 640, pixels per row
ROWS, 480, rows per frame; FRAME_PIXELS = ROWLENGTH*ROWS (localparam)
DATA_WIDTH, 12, pixel width in bits
ADDR_WIDTH, 19, BRAM address width; must satisfy 2**ADDR_WIDTH >= FRAME_PIXELS

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
o_rd  output  1  front FIFO read enable
i_rdata  input  DATA_WIDTH  front FIFO read data, valid the cycle after o_rd
i_almostempty  input  1  front FIFO almost-empty flag
o_wr  output  1  back FIFO write enable
o_wdata  output  DATA_WIDTH  back FIFO write data
i_almostfull  input  1  back FIFO almost-full flag
i_req  input  1  single-cycle frame request from the display interface, already in i_clk domain
i_frame_sync  input  1  single-cycle start-of-frame pulse, already in i_clk domain
i_freeze  input  1  level; requests freeze of the buffered frame
o_busy  output  1  high while a frame is being streamed out
o_frozen  output  1  freeze currently in effect
o_wframe_done  output  1  one-cycle pulse when the write address wraps
o_req_overrun  output  1  one-cycle pulse when i_req arrives while o_busy

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; waddr = raddr = 0; rd_pending = 0; read FSM in IDLE.
  - BRAM contents are not cleared.
  - Reset mid-stream abandons the stream; the in-flight BRAM read produces no o_wr.
- Write side:
  - o_rd = !i_almostempty, registered (one read per cycle while not almost-empty).
  - rd_pending = o_rd delayed one cycle.
  - When rd_pending: if !o_frozen, write i_rdata to mem[waddr]. waddr increments whether or not the write occurs.
  - At waddr == FRAME_PIXELS-1 with rd_pending: waddr <= 0 and o_wframe_done pulses the next cycle.
- Frame sync:
  - i_frame_sync without rd_pending: waddr <= 0.
  - i_frame_sync with rd_pending in the same cycle: the word goes to address 0 and waddr <= 1.
  - Sync takes priority over wrap; no o_wframe_done pulse on a sync-forced reset.
- Freeze:
  - o_frozen updates only at a frame boundary, i.e. a cycle where waddr becomes 0 by wrap or sync. At that point o_frozen <= i_freeze.
  - Therefore a frozen frame is always complete, and unfreeze also waits for a boundary.
  - While frozen, the front FIFO is still drained (o_rd behaves normally) and the data is discarded.
- Read FSM:
  - IDLE:
    - o_busy = 0.
    - On i_req: go to STREAM, raddr <= 0.
  - STREAM:
    - o_busy = 1.
    - Each cycle with !i_almostfull: issue a BRAM read of mem[raddr] and raddr++.
    - On issuing address FRAME_PIXELS-1: go to IDLE.
    - A cycle with i_almostfull issues nothing and holds raddr.
- Read output timing:
  - BRAM read latency is 1 cycle: o_wr and o_wdata are registered one cycle after issue.
  - The final o_wr of a frame occurs the cycle after the return to IDLE.
  - Exactly FRAME_PIXELS o_wr pulses per i_req, in address order.
- i_req handling:
  - i_req in STREAM is ignored and pulses o_req_overrun the next cycle.
  - i_req in the same cycle as the final issue is also ignored.
- Concurrency: BRAM is simple dual-port; a same-address write and read in one cycle returns the old data (read-first).
- Widths: address counters are ADDR_WIDTH wide and compare against FRAME_PIXELS-1. No arithmetic is performed on pixel data.

Test Plan:
1. ROWLENGTH=4, ROWS=2 (8 pixels). Feed 0..7 via FIFO model, then pulse i_req with i_almostfull=0 -> o_wr high for 8 consecutive cycles, o_wdata 0..7; o_busy high for 8 cycles; one o_wframe_done pulse after word 7 is written.
2. Toggle i_almostfull during STREAM (high for 3 cycles after the 2nd word) -> no o_wr during the stall plus one cycle; sequence still 0..7 with no duplicates or drops.
3. Set i_freeze=1 mid-frame while writing frame B (values 100..107) -> frame B is still fully written (freeze waits for the boundary); o_frozen rises at the wrap; frame C (200..207) is drained but discarded; i_req returns 100..107.
4. i_frame_sync after 3 words of frame D (10,11,12), then write 20..27 -> mem[0..7] = 20..27; no o_wframe_done on the sync; the next wrap pulses o_wframe_done.
5. Second i_req during STREAM -> o_req_overrun is a single-cycle pulse; exactly 8 o_wr occur, and no second stream starts.
6. Assert i_rst after 4 words streamed -> all outputs 0 immediately; no further o_wr; a new i_req after release streams all 8 words from address 0.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// Single-frame buffer between the camera-side and display-side CDC FIFOs.
// The front FIFO is drained into a one-frame BRAM. Each display request
// streams the stored frame out in address order. The block also supports
// frame-sync realignment and a freeze that only takes effect on frame boundaries.
module frame_buffer_ctrl #(
  parameter int ROWLENGTH  = 640,
  parameter int ROWS       = 480,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_almostempty,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_almostfull,
  input  logic                  i_req,
  input  logic                  i_frame_sync,
  input  logic                  i_freeze,
  output logic                  o_busy,
  output logic                  o_frozen,
  output logic                  o_wframe_done,
  output logic                  o_req_overrun
);
  localparam int FRAME_PIXELS = ROWLENGTH * ROWS;
  localparam int MEM_AW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_WIDTH-1:0] mem [FRAME_PIXELS];
  logic [ADDR_WIDTH-1:0] waddr, raddr, raddr_nxt, wr_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_pending, wrap, wr_en, issue;
  state_t                state, state_nxt;

  // A sync that arrives together with a data word places that word at address 0.
  assign wrap    = rd_pending && (waddr == LAST);
  assign wr_addr = i_frame_sync ? '0 : waddr;
  assign wr_en   = rd_pending && !o_frozen;
  assign o_busy  = (state == STREAM);
  // The read word is gated so the data bus idles at zero, including out of reset.
  assign o_wdata = o_wr ? rd_word : '0;

  // Simple dual-port BRAM. The read is read-first: a same-cycle write to the same address is not seen.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr[MEM_AW-1:0]] <= i_rdata;
    if (issue) rd_word <= mem[raddr[MEM_AW-1:0]];
  end

  // Write side. Drain the front FIFO, advance the write address, and latch freeze on boundaries.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd          <= 1'b0;
      rd_pending    <= 1'b0;
      waddr         <= '0;
      o_frozen      <= 1'b0;
      o_wframe_done <= 1'b0;
    end else begin
      o_rd          <= !i_almostempty;
      rd_pending    <= o_rd;
      o_wframe_done <= wrap && !i_frame_sync;
      if (i_frame_sync)    waddr <= rd_pending ? ADDR_WIDTH'(1) : '0;
      else if (wrap)       waddr <= '0;
      else if (rd_pending) waddr <= waddr + 1'b1;
      if (i_frame_sync || wrap) o_frozen <= i_freeze;
    end
  end

  // Read FSM state, read address, and registered output strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      raddr         <= '0;
      o_wr          <= 1'b0;
      o_req_overrun <= 1'b0;
    end else begin
      state         <= state_nxt;
      raddr         <= raddr_nxt;
      o_wr          <= issue;
      o_req_overrun <= i_req && (state == STREAM);
    end
  end

  // Next-state logic. One BRAM read is issued per cycle while the back FIFO has room.
  always_comb begin
    state_nxt = state;
    raddr_nxt = raddr;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req) begin
          state_nxt = STREAM;
          raddr_nxt = '0;
        end
      end
      STREAM: begin
        if (!i_almostfull) begin
          issue     = 1'b1;
          raddr_nxt = raddr + 1'b1;
          if (raddr == LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl on an 8-pixel frame. The front FIFO is modelled
// as a source array, and the expected frame contents are kept in a reference array.
module tb_frame_buffer_ctrl;
  localparam int DW = 12;
  localparam int FP = 8;

  logic          i_clk = 1'b0, i_rst = 1'b1;
  logic          o_rd, o_wr, o_busy, o_frozen, o_wframe_done, o_req_overrun;
  logic [DW-1:0] i_rdata = '0, o_wdata;
  logic          i_almostempty = 1'b1, i_almostfull = 1'b0;
  logic          i_req = 1'b0, i_frame_sync = 1'b0, i_freeze = 1'b0;

  frame_buffer_ctrl #(.ROWLENGTH(4), .ROWS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_rd(o_rd), .i_rdata(i_rdata),
    .i_almostempty(i_almostempty), .o_wr(o_wr), .o_wdata(o_wdata),
    .i_almostfull(i_almostfull), .i_req(i_req), .i_frame_sync(i_frame_sync),
    .i_freeze(i_freeze), .o_busy(o_busy), .o_frozen(o_frozen),
    .o_wframe_done(o_wframe_done), .o_req_overrun(o_req_overrun)
  );

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;

  // Front FIFO model. The test appends words to src, and the feeder hands them out after o_rd.
  logic [DW-1:0] src [4096];
  int src_n = 0, src_rd = 0;
  logic fe_hold = 1'b0, ord_d = 1'b0;
  always @(negedge i_clk) begin
    if (ord_d && src_rd < src_n) begin
      i_rdata = src[src_rd];
      src_rd  = src_rd + 1;
    end
    ord_d = o_rd;
    i_almostempty = fe_hold || ((src_n - src_rd) <= (o_rd ? 1 : 0));
  end

  // Output monitor. It keeps cumulative counts that the test compares as deltas.
  logic [DW-1:0] wr_q[$];
  int busy_n = 0, wfd_n = 0, ov_n = 0;
  always @(negedge i_clk) begin
    if (o_wr) wr_q.push_back(o_wdata);
    if (o_busy) busy_n = busy_n + 1;
    if (o_wframe_done) wfd_n = wfd_n + 1;
    if (o_req_overrun) ov_n = ov_n + 1;
  end

  // Reference model. It holds the frame contents and the next write position.
  logic [DW-1:0] ref_mem [FP];
  int ref_wp = 0;

  task automatic chk(string name, int act, int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Push n words. If store is set, the words are expected to land in memory.
  task automatic feed(int base, int n, bit rnd, bit store, string tag);
    int w0, exp_w, t;
    logic [DW-1:0] v;
    w0 = wfd_n; exp_w = 0;
    for (int i = 0; i < n; i++) begin
      v = rnd ? DW'($urandom_range(0, 4095)) : DW'(base + i);
      src[src_n] = v;
      src_n = src_n + 1;
      if (store) ref_mem[ref_wp] = v;
      if (ref_wp == FP - 1) begin ref_wp = 0; exp_w++; end
      else ref_wp++;
    end
    t = 0;
    while (src_rd != src_n && t < 300) begin
      @(negedge i_clk);
      if (rnd) fe_hold = 1'($urandom_range(0, 1));
      t++;
    end
    fe_hold = 1'b0;
    repeat (4) @(negedge i_clk);
    chk({tag, " drained"}, src_rd, src_n);
    chk({tag, " wframe_done count"}, wfd_n - w0, exp_w);
  endtask

  // Request one frame. Bit c of mask drives i_almostfull on stream cycle c.
  task automatic stream(logic [15:0] mask, int exp_busy, string tag);
    int s0, b0;
    s0 = wr_q.size(); b0 = busy_n;
    @(negedge i_clk); i_req = 1'b1;
    @(negedge i_clk); i_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      i_almostfull = (c < 16) ? mask[c] : 1'b0;
      @(negedge i_clk);
    end
    i_almostfull = 1'b0;
    chk({tag, " o_wr count"}, wr_q.size() - s0, FP);
    chk({tag, " busy cycles"}, busy_n - b0, exp_busy);
    chk({tag, " idle after"}, int'(o_busy), 0);
    for (int i = 0; i < FP; i++)
      if (s0 + i < wr_q.size()) chk({tag, " word"}, int'(wr_q[s0 + i]), int'(ref_mem[i]));
  endtask

  function automatic int busy_for(logic [15:0] mask);
    int c = 0, n = 0;
    while (n < FP) begin
      if (!(c < 16 && mask[c])) n++;
      c++;
    end
    return c;
  endfunction

  typedef struct {
    int          base;
    logic [15:0] mask;
    int          exp_busy;
  } vec_t;

  initial begin
    vec_t vt [4];
    int s0, o0, b0, t;
    vt[0] = '{0,  16'h0000, 8};
    vt[1] = '{40, 16'h001C, 11};
    vt[2] = '{60, 16'h0155, 13};
    vt[3] = '{90, 16'h8000, 8};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("reset outputs", int'({o_rd, o_wr, o_busy, o_frozen, o_wframe_done, o_req_overrun}), 0);
    chk("reset wdata", int'(o_wdata), 0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // Table-driven frames with back-pressure patterns
    foreach (vt[k]) begin
      feed(vt[k].base, FP, 1'b0, 1'b1, "table feed");
      stream(vt[k].mask, vt[k].exp_busy, "table stream");
    end

    // Frame sync after three words realigns the frame to address 0
    feed(10, 3, 1'b0, 1'b1, "sync partial");
    o0 = wfd_n;
    @(negedge i_clk); i_frame_sync = 1'b1;
    @(negedge i_clk); i_frame_sync = 1'b0;
    ref_wp = 0;
    repeat (3) @(negedge i_clk);
    chk("sync no wframe_done", wfd_n - o0, 0);
    feed(20, FP, 1'b0, 1'b1, "sync frame");
    stream(16'h0, 8, "sync stream");

    // Freeze raised mid-frame takes effect at the wrap
    feed(100, 4, 1'b0, 1'b1, "freeze B lo");
    i_freeze = 1'b1;
    @(negedge i_clk);
    chk("not frozen mid-frame", int'(o_frozen), 0);
    feed(104, 4, 1'b0, 1'b1, "freeze B hi");
    chk("frozen at wrap", int'(o_frozen), 1);
    feed(200, FP, 1'b0, 1'b0, "frozen C");
    chk("still frozen", int'(o_frozen), 1);
    stream(16'h0, 8, "frozen stream");
    i_freeze = 1'b0;
    feed(30, FP, 1'b0, 1'b0, "unfreeze frame");
    chk("unfrozen at wrap", int'(o_frozen), 0);
    stream(16'h0024, 10, "after unfreeze stream");

    // A second request during streaming gives one overrun pulse and no restart
    feed(50, FP, 1'b0, 1'b1, "overrun feed");
    s0 = wr_q.size(); o0 = ov_n; b0 = busy_n;
    @(negedge i_clk); i_req = 1'b1;
    @(negedge i_clk); i_req = 1'b0;
    repeat (2) @(negedge i_clk);
    i_req = 1'b1;
    @(negedge i_clk); i_req = 1'b0;
    repeat (30) @(negedge i_clk);
    chk("overrun pulses", ov_n - o0, 1);
    chk("overrun o_wr count", wr_q.size() - s0, FP);
    chk("overrun busy cycles", busy_n - b0, 8);
    for (int i = 0; i < FP; i++)
      if (s0 + i < wr_q.size()) chk("overrun word", int'(wr_q[s0 + i]), int'(ref_mem[i]));

    // Reset in the middle of a stream
    s0 = wr_q.size();
    @(negedge i_clk); i_req = 1'b1;
    @(negedge i_clk); i_req = 1'b0;
    t = 0;
    while (wr_q.size() - s0 < 4 && t < 50) begin @(negedge i_clk); t++; end
    chk("reset stream started", int'(wr_q.size() - s0 >= 4), 1);
    i_rst = 1'b1;
    #1;
    chk("mid reset outputs", int'({o_rd, o_wr, o_busy, o_frozen, o_wframe_done, o_req_overrun}), 0);
    s0 = wr_q.size();
    repeat (5) @(negedge i_clk);
    chk("no o_wr after reset", wr_q.size() - s0, 0);
    i_rst = 1'b0;
    ref_wp = 0;
    repeat (2) @(negedge i_clk);
    stream(16'h0, 8, "post reset stream");

    // Randomized bursts checked against the reference model
    for (int it = 0; it < 8; it++) begin
      logic [15:0] m;
      feed(0, $urandom_range(1, 14), 1'b1, 1'b1, "rand feed");
      if (ref_wp == 0 || $urandom_range(0, 1) == 1) begin
        m = 16'($urandom);
        stream(m, busy_for(m), "rand stream");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
